mem_data_interface: RTL and testbench

- Holds the CPU's MAR and MDR and runs the word-wide memory read/write handshake.
- Sits directly upstream of the 32-to-1 bus multiplexer: mdr_out drives the multiplexer's MDR input (select code 21).
- Loads MAR/MDR from the bus output under control-unit strobes and fills MDR from memory on reads.
- Memory-side handshake is req/ack with a bounded wait and an error flag.

---
 rtl/mem_data_interface_pkg.sv | 10 +
 rtl/mem_data_interface_register32.sv | 16 +
 rtl/mem_data_interface.sv | 93 +++++++++
 tb/tb_mem_data_interface.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_data_interface_pkg.sv
// mem_data_interface_pkg: shared state encoding and constants for the MAR/MDR memory interface
package mem_data_interface_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;
  localparam logic [4:0] MDR_SEL = 5'd21;
  localparam int ADDR_W_DEF = 9;
endpackage

// File: rtl/mem_data_interface_register32.sv
// register32: 32-bit register with synchronous clear and load enable
module register32 (
  input  logic        clock,
  input  logic        clear,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);
  logic [31:0] r_q;
  // clear wins over load; otherwise hold
  always_ff @(posedge clock) begin
    if (clear) r_q <= '0;
    else if (i_load) r_q <= i_d;
  end
  assign o_q = r_q;
endmodule

// File: rtl/mem_data_interface.sv
// mem_data_interface: MAR/MDR holder and req/ack memory handshake with bounded wait
module mem_data_interface
  import mem_data_interface_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_out,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_done, r_err;
  logic        w_idle, w_timeout, w_mar_ld, w_mdr_ld;
  logic [31:0] w_mar, w_mdr, w_mdr_d;
  logic        w_unused;

  assign w_idle    = r_state == IDLE;
  assign w_timeout = !w_idle && !mem_ack && r_cnt == 8'(TIMEOUT - 1);
  assign w_mar_ld  = w_idle && mar_in;
  assign w_mdr_ld  = (w_idle && mdr_in) || (r_state == RD_WAIT && mem_ack);
  assign w_mdr_d   = w_idle ? bus_in : mem_data_in;

  register32 u_mar (
    .clock (clock),
    .clear (clear),
    .i_load(w_mar_ld),
    .i_d   (bus_in),
    .o_q   (w_mar)
  );

  register32 u_mdr (
    .clock (clock),
    .clear (clear),
    .i_load(w_mdr_ld),
    .i_d   (w_mdr_d),
    .o_q   (w_mdr)
  );

  // state register
  always_ff @(posedge clock) begin
    if (clear) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state: a lone request starts an access, ack or timeout ends it
  always_comb begin
    w_next = w_idle ? ((rd_req ^ wr_req) ? (rd_req ? RD_WAIT : WR_WAIT) : IDLE)
                    : ((mem_ack || w_timeout) ? IDLE : r_state);
  end

  // wait counter and registered completion/error pulses
  always_ff @(posedge clock) begin
    if (clear) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_idle ? 8'd0 : r_cnt + 8'd1;
      r_done <= !w_idle && mem_ack;
      r_err  <= (w_idle && rd_req && wr_req) || w_timeout;
    end
  end

  // outputs decoded from state and held registers
  always_comb begin
    mem_rd       = r_state == RD_WAIT;
    mem_wr       = r_state == WR_WAIT;
    busy         = !w_idle;
    done         = r_done;
    err          = r_err;
    mem_addr     = w_mar[ADDR_W-1:0];
    mem_data_out = w_mdr;
    mdr_out      = w_mdr;
  end

  assign w_unused = ^w_mar[31:ADDR_W];
endmodule

// File: tb/tb_mem_data_interface.sv
// tb_mem_data_interface: scoreboard bench for the MAR/MDR memory interface
module tb_mem_data_interface;
  logic        clock = 0, clear = 1;
  logic [31:0] bus_in = '0, mem_data_in = '0;
  logic        mar_in = 0, mdr_in = 0, rd_req = 0, wr_req = 0, mem_ack = 0;
  logic [8:0]  mem_addr;
  logic [31:0] mem_data_out, mdr_out;
  logic        mem_rd, mem_wr, busy, done, err;

  typedef struct {
    logic        done;
    logic        err;
    logic [31:0] mdr;
  } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0, rd_cnt = 0, wr_cnt = 0;

  mem_data_interface dut (
    .clock(clock), .clear(clear), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .rd_req(rd_req), .wr_req(wr_req), .mem_ack(mem_ack), .mem_data_in(mem_data_in),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // strobe counters and completion scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    if (mem_rd) rd_cnt++;
    if (mem_wr) wr_cnt++;
    if (done || err) begin
      if (sb.size() == 0) check("unexpected_pulse", {30'd0, done, err}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("done", {31'd0, done}, {31'd0, e.done});
        check("err", {31'd0, err}, {31'd0, e.err});
        check("mdr", mdr_out, e.mdr);
      end
    end
  end

  initial begin
    tick();
    clear = 0;
    check("rst_mdr", mdr_out, 0);
    check("rst_addr", {23'd0, mem_addr}, 0);
    check("rst_flags", {27'd0, busy, mem_rd, mem_wr, done, err}, 0);

    // zero-wait read
    bus_in = 32'h0000_0045; mar_in = 1;
    tick();
    mar_in = 0; rd_req = 1; mem_ack = 1; mem_data_in = 32'hDEAD_BEEF; rd_cnt = 0;
    sb.push_back('{1'b1, 1'b0, 32'hDEAD_BEEF});
    tick();
    rd_req = 0;
    check("zw_addr", {23'd0, mem_addr}, 32'h045);
    check("zw_rd", {31'd0, mem_rd}, 1);
    tick();
    mem_ack = 0;
    check("zw_rd_off", {31'd0, mem_rd}, 0);
    check("zw_rd_len", rd_cnt, 1);
    check("zw_mdr", mdr_out, 32'hDEAD_BEEF);

    // write with three wait cycles
    bus_in = 32'h1234_5678; mdr_in = 1; mem_data_in = 32'hFFFF_0000;
    tick();
    mdr_in = 0; wr_req = 1; wr_cnt = 0;
    sb.push_back('{1'b1, 1'b0, 32'h1234_5678});
    tick();
    wr_req = 0;
    for (int i = 0; i < 3; i++) begin
      check("wr_data", mem_data_out, 32'h1234_5678);
      tick();
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("wr_len", wr_cnt, 4);
    check("wr_mdr_kept", mdr_out, 32'h1234_5678);

    // read timeout keeps prior MDR
    bus_in = 32'hA5A5_A5A5; mdr_in = 1;
    tick();
    mdr_in = 0; rd_req = 1; rd_cnt = 0;
    sb.push_back('{1'b0, 1'b1, 32'hA5A5_A5A5});
    tick();
    rd_req = 0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("to_bound", {31'd0, busy}, 0);
    tick(); tick();
    check("to_len", rd_cnt, 15);
    check("to_mdr", mdr_out, 32'hA5A5_A5A5);

    // conflicting requests
    rd_req = 1; wr_req = 1; rd_cnt = 0; wr_cnt = 0;
    sb.push_back('{1'b0, 1'b1, 32'hA5A5_A5A5});
    tick();
    rd_req = 0; wr_req = 0;
    tick();
    check("cf_busy", {31'd0, busy}, 0);
    check("cf_strobes", rd_cnt + wr_cnt, 0);

    // busy lockout of MAR/MDR loads
    rd_req = 1;
    tick();
    rd_req = 0; bus_in = 32'hFFFF_FFFF; mar_in = 1; mdr_in = 1;
    tick();
    mar_in = 0; mdr_in = 0;
    check("lk_addr", {23'd0, mem_addr}, 32'h045);
    check("lk_mdr", mdr_out, 32'hA5A5_A5A5);
    mem_ack = 1; mem_data_in = 32'h0BAD_F00D;
    sb.push_back('{1'b1, 1'b0, 32'h0BAD_F00D});
    tick();
    mem_ack = 0;
    check("lk_addr_idle", {23'd0, mem_addr}, 32'h045);
    mar_in = 1;
    tick();
    mar_in = 0;
    check("addr_top", {23'd0, mem_addr}, 32'h1FF);

    // clear aborts a write with ack pending
    wr_req = 1;
    tick();
    wr_req = 0;
    check("mc_wr", {31'd0, mem_wr}, 1);
    mem_ack = 1; clear = 1;
    tick();
    clear = 0; mem_ack = 0;
    check("mc_flags", {27'd0, busy, mem_rd, mem_wr, done, err}, 0);
    check("mc_mdr", mdr_out, 0);
    check("mc_addr", {23'd0, mem_addr}, 0);
    tick(); tick();

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
